control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 35 +++
 rtl/control_sequencer.sv | 157 +++++++++++++++
 tb/tb_control_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Instruction request and control-word bundle between the sequencer and its datapath.
// The slave side is the sequencer; the master side issues instructions and consumes enables.
interface control_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 8
);
    logic              new_instr;
    logic [DATA_W-1:0] instr;
    logic [NREG-1:0]   rin;
    logic [NREG-1:0]   rout;
    logic              gin;
    logic              gout;
    logic              a_in;
    logic              pcin;
    logic              pcout;
    logic              addsub;
    logic              xorctrl;
    logic              ctrl_out;
    logic [DATA_W-1:0] out;
    logic              busy;
    logic              done;
    logic              illegal;

    modport master (
        output new_instr, instr,
        input  rin, rout, gin, gout, a_in, pcin, pcout, addsub, xorctrl,
        input  ctrl_out, out, busy, done, illegal
    );

    modport slave (
        input  new_instr, instr,
        output rin, rout, gin, gout, a_in, pcin, pcout, addsub, xorctrl,
        output ctrl_out, out, busy, done, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: latches an instruction into IR and steps IDLE/T1/T2/T3,
// decoding register, ALU and PC enables from the registered state and IR only.
module control_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 8
) (
    input logic                clk,
    input logic                rst,
    control_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StT1, StT2, StT3} state_e;

    localparam logic [3:0] OpLoad   = 4'h0;
    localparam logic [3:0] OpMove   = 4'h1;
    localparam logic [3:0] OpAdd    = 4'h2;
    localparam logic [3:0] OpSub    = 4'h3;
    localparam logic [3:0] OpXor    = 4'h4;
    localparam logic [3:0] OpLdpc   = 4'h5;
    localparam logic [3:0] OpBranch = 4'h6;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q;
    logic [3:0]        op, rx, ry;
    logic [DATA_W-1:0] imm;
    logic              is_alu, uses_ry, legal, accept;
    logic              rin_en, rout_en;
    logic [3:0]        rin_idx, rout_idx;
    logic [NREG-1:0]   rin, rout;
    logic              gin, gout, a_in, pcin, pcout, addsub, xorctrl, ctrl_out, done, illegal;

    assign op  = ir_q[DATA_W-1 -: 4];
    assign rx  = ir_q[DATA_W-5 -: 4];
    assign ry  = ir_q[DATA_W-9 -: 4];
    assign imm = {{8{1'b0}}, ir_q[DATA_W-9:0]};

    assign is_alu  = (op == OpAdd) || (op == OpSub) || (op == OpXor);
    assign uses_ry = is_alu || (op == OpMove);
    assign legal   = (op <= OpBranch) && (32'(rx) < NREG) && (!uses_ry || (32'(ry) < NREG));

    // Control word: everything is decoded from state_q/ir_q, so reset to IDLE clears it at once.
    always_comb begin
        rin_en   = 1'b0;
        rin_idx  = rx;
        rout_en  = 1'b0;
        rout_idx = rx;
        gin      = 1'b0;
        gout     = 1'b0;
        a_in     = 1'b0;
        pcin     = 1'b0;
        pcout    = 1'b0;
        addsub   = 1'b0;
        xorctrl  = 1'b0;
        ctrl_out = 1'b0;
        done     = 1'b0;
        illegal  = 1'b0;
        unique case (state_q)
            StT1: begin
                if (!legal) begin
                    illegal = 1'b1;
                    done    = 1'b1;
                end else if (is_alu) begin
                    rout_en = 1'b1;
                    a_in    = 1'b1;
                end else begin
                    done = 1'b1;
                    case (op)
                        OpLoad: begin
                            ctrl_out = 1'b1;
                            rin_en   = 1'b1;
                        end
                        OpMove: begin
                            rout_en  = 1'b1;
                            rout_idx = ry;
                            rin_en   = 1'b1;
                        end
                        OpLdpc: begin
                            pcout  = 1'b1;
                            rin_en = 1'b1;
                        end
                        OpBranch: begin
                            rout_en = 1'b1;
                            pcin    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StT2: begin
                rout_en  = 1'b1;
                rout_idx = ry;
                gin      = 1'b1;
                addsub   = (op == OpSub);
                xorctrl  = (op == OpXor);
            end
            StT3: begin
                gout   = 1'b1;
                rin_en = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        rin  = '0;
        rout = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            rin[i]  = rin_en && (32'(rin_idx) == i);
            rout[i] = rout_en && (32'(rout_idx) == i);
        end
    end

    // Accepting in a done cycle gives zero-bubble back-to-back issue.
    assign accept = bus.new_instr && ((state_q == StIdle) || done);

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = StT1;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StT1:   state_d = done ? StIdle : StT2;
                StT2:   state_d = StT3;
                StT3:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ir_q <= bus.instr;
            end
        end
    end

    assign bus.rin      = rin;
    assign bus.rout     = rout;
    assign bus.gin      = gin;
    assign bus.gout     = gout;
    assign bus.a_in     = a_in;
    assign bus.pcin     = pcin;
    assign bus.pcout    = pcout;
    assign bus.addsub   = addsub;
    assign bus.xorctrl  = xorctrl;
    assign bus.ctrl_out = ctrl_out;
    assign bus.out      = ctrl_out ? imm : '0;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done;
    assign bus.illegal  = illegal;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector bench for control_sequencer: an NREG=8 instance checked row by row, and an
// NREG=16 instance sharing the stimulus for the register-range corner case.
module tb_control_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_sequencer_if #(.DATA_W(16), .NREG(8))  ifa ();
    control_sequencer_if #(.DATA_W(16), .NREG(16)) ifb ();

    control_sequencer #(.DATA_W(16), .NREG(8))  dut_a (.clk(clk), .rst(rst), .bus(ifa));
    control_sequencer #(.DATA_W(16), .NREG(16)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Flag word order: busy done illegal ctrl_out gin gout a_in pcin pcout addsub xorctrl
    localparam logic [10:0] FB = 11'h400, FD = 11'h200, FI = 11'h100, FC = 11'h080;
    localparam logic [10:0] GI = 11'h040, GO = 11'h020, AI = 11'h010, PI = 11'h008;
    localparam logic [10:0] PO = 11'h004, AS = 11'h002, XC = 11'h001;

    typedef struct {
        logic        ni;
        logic [15:0] instr;
        logic [7:0]  rin;
        logic [7:0]  rout;
        logic [10:0] flags;
        logic [15:0] out;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [10:0] flags_a();
        return {ifa.busy, ifa.done, ifa.illegal, ifa.ctrl_out, ifa.gin, ifa.gout, ifa.a_in,
                ifa.pcin, ifa.pcout, ifa.addsub, ifa.xorctrl};
    endfunction

    task automatic drive(input logic ni, input logic [15:0] instr);
        ifa.new_instr = ni;
        ifa.instr     = instr;
        ifb.new_instr = ni;
        ifb.instr     = instr;
    endtask

    task automatic check_a(input string name, input logic [7:0] erin, input logic [7:0] erout,
                           input logic [10:0] ef, input logic [15:0] eout);
        n_vec++;
        if (ifa.rin !== erin || ifa.rout !== erout || flags_a() !== ef || ifa.out !== eout) begin
            n_bad++;
            $display("FAIL %s: got rin=%h rout=%h flags=%b out=%h, want rin=%h rout=%h flags=%b out=%h",
                     name, ifa.rin, ifa.rout, flags_a(), ifa.out, erin, erout, ef, eout);
        end
    endtask

    initial begin
        drive(1'b0, 16'h0000);
        // Each row: inputs held for one cycle, outputs expected in the following cycle.
        vecs.push_back(vec_t'{1'b1, 16'h02FF, 8'h04, 8'h00, FB | FD | FC, 16'h00FF}); // LOAD
        vecs.push_back(vec_t'{1'b0, 16'h02FF, 8'h00, 8'h00, 11'h000, 16'h0000});
        vecs.push_back(vec_t'{1'b1, 16'h1610, 8'h40, 8'h02, FB | FD, 16'h0000});      // MOVE
        vecs.push_back(vec_t'{1'b0, 16'h0000, 8'h00, 8'h00, 11'h000, 16'h0000});
        vecs.push_back(vec_t'{1'b1, 16'h2260, 8'h00, 8'h04, FB | AI, 16'h0000});      // ADD T1
        vecs.push_back(vec_t'{1'b1, 16'h02FF, 8'h00, 8'h40, FB | GI, 16'h0000});      // ignored
        vecs.push_back(vec_t'{1'b0, 16'h1111, 8'h04, 8'h00, FB | FD | GO, 16'h0000}); // ADD T3
        vecs.push_back(vec_t'{1'b1, 16'h6700, 8'h00, 8'h80, FB | FD | PI, 16'h0000}); // BRANCH
        vecs.push_back(vec_t'{1'b0, 16'h0000, 8'h00, 8'h00, 11'h000, 16'h0000});
        vecs.push_back(vec_t'{1'b1, 16'h3260, 8'h00, 8'h04, FB | AI, 16'h0000});      // SUB
        vecs.push_back(vec_t'{1'b0, 16'h0000, 8'h00, 8'h40, FB | GI | AS, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 16'h0000, 8'h04, 8'h00, FB | FD | GO, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 16'h0000, 8'h00, 8'h00, 11'h000, 16'h0000});
        vecs.push_back(vec_t'{1'b1, 16'h4120, 8'h00, 8'h02, FB | AI, 16'h0000});      // XOR
        vecs.push_back(vec_t'{1'b0, 16'h0000, 8'h00, 8'h04, FB | GI | XC, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 16'h0000, 8'h02, 8'h00, FB | FD | GO, 16'h0000});
        vecs.push_back(vec_t'{1'b1, 16'h5300, 8'h08, 8'h00, FB | FD | PO, 16'h0000}); // LDPC
        vecs.push_back(vec_t'{1'b1, 16'h0901, 8'h00, 8'h00, FB | FD | FI, 16'h0000}); // rx=9
        vecs.push_back(vec_t'{1'b1, 16'h7000, 8'h00, 8'h00, FB | FD | FI, 16'h0000}); // bad op
        vecs.push_back(vec_t'{1'b1, 16'h1190, 8'h00, 8'h00, FB | FD | FI, 16'h0000}); // ry=9
        vecs.push_back(vec_t'{1'b1, 16'h2180, 8'h00, 8'h00, FB | FD | FI, 16'h0000}); // ry=8
        vecs.push_back(vec_t'{1'b0, 16'h0000, 8'h00, 8'h00, 11'h000, 16'h0000});
        vecs.push_back(vec_t'{1'b1, 16'h07AB, 8'h80, 8'h00, FB | FD | FC, 16'h00AB}); // LOAD r7
        vecs.push_back(vec_t'{1'b0, 16'h07AB, 8'h00, 8'h00, 11'h000, 16'h0000});

        #2 rst = 1'b0;
        #1 check_a("reset_async", 8'h00, 8'h00, 11'h000, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ni, vecs[i].instr);
            @(negedge clk);
            check_a($sformatf("vec%0d", i), vecs[i].rin, vecs[i].rout, vecs[i].flags,
                    vecs[i].out);
        end

        // Reset asserted in the middle of ADD T2, then released with no request pending.
        drive(1'b1, 16'h2260);
        @(negedge clk);
        drive(1'b0, 16'h0000);
        @(negedge clk);
        check_a("rst_pre_t2", 8'h00, 8'h40, FB | GI, 16'h0000);
        #1 rst = 1'b0;
        #1 check_a("rst_mid_t2", 8'h00, 8'h00, 11'h000, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_a("post_rst_idle", 8'h00, 8'h00, 11'h000, 16'h0000);
        @(negedge clk);
        check_a("no_resume", 8'h00, 8'h00, 11'h000, 16'h0000);

        // Same LOAD word is illegal with 8 registers, legal with 16.
        drive(1'b1, 16'h0901);
        @(negedge clk);
        check_a("illegal_rx9", 8'h00, 8'h00, FB | FD | FI, 16'h0000);
        n_vec++;
        if (ifb.rin !== 16'h0200 || ifb.rout !== 16'h0000 || ifb.illegal !== 1'b0 ||
            ifb.done !== 1'b1 || ifb.ctrl_out !== 1'b1 || ifb.out !== 16'h0001) begin
            n_bad++;
            $display("FAIL nreg16_load: got rin=%h illegal=%b done=%b ctrl_out=%b out=%h, want rin=0200 illegal=0 done=1 ctrl_out=1 out=0001",
                     ifb.rin, ifb.illegal, ifb.done, ifb.ctrl_out, ifb.out);
        end
        drive(1'b0, 16'h0000);
        @(negedge clk);
        check_a("final_idle", 8'h00, 8'h00, 11'h000, 16'h0000);
        n_vec++;
        if (ifb.busy !== 1'b0 || ifb.rin !== 16'h0000) begin
            n_bad++;
            $display("FAIL nreg16_idle: got busy=%b rin=%h, want busy=0 rin=0000",
                     ifb.busy, ifb.rin);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
